branch_seq: RTL

- Multi-cycle branch sequencer for the microcoded LEGv8 datapath.
- Accepts a latched branch-class instruction, evaluates the branch condition, optionally writes the link register, then issues the PC-update control word.
- Emits the standard 31-bit control word and a DATA_W-bit K constant each cycle.
- Covers B, BL, B.cond, CBZ, CBNZ and BR under one internal FSM, with sign-extended offsets and a start/done handshake.

---
 rtl/branch_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_seq.sv
// branch_seq: multi-cycle LEGv8 branch sequencer.
// Evaluates a latched branch, optionally links, then issues the PC update.
module branch_seq #(
  parameter int unsigned DATA_W      = 64,
  parameter logic [4:0]  LINK_REG    = 5'd30,
  parameter bit          LINK_EN     = 1'b1,
  parameter logic [4:0]  FSEL_PASS_A = 5'b00000,
  parameter logic [4:0]  FSEL_PASS_B = 5'b00001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instruction,
  input  logic [4:0]        status,
  output logic [30:0]       controlword,
  output logic [DATA_W-1:0] K,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE, S_EVAL, S_LINK, S_JUMP
  } state_e;

  typedef enum logic [2:0] {
    C_B, C_BL, C_BC, C_CBZ, C_CBNZ, C_BR, C_ILL
  } cls_e;

  typedef struct packed {
    logic [1:0] psel;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fsel;
    logic       regw;
    logic       ramw;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       bsel;
    logic       pcsel;
    logic       sl;
  } cw_t;

  localparam cw_t CW_NOP =
    cw_t'({2'b00, 5'd31, 5'd31, 5'd31, 14'd0});

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [3:0]        flags_q, flags_d;
  logic              tk_q, tk_d;
  cw_t               cw_q, cw_d;
  logic [DATA_W-1:0] k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              idle;
  logic [31:0]       ins;
  cls_e              cls;
  logic [DATA_W-1:0] kval;
  logic              cond_ok;
  logic              eval_tk;

  // In IDLE the word on the port is the one about to be latched.
  assign idle = (state_q == S_IDLE);
  assign ins  = idle ? instruction : instr_q;

  // Classify the active instruction word.
  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      ins[31:26] == 6'b000101:       cls = C_B;
      ins[31:26] == 6'b100101:       cls = C_BL;
      ins[31:24] == 8'b10110100:     cls = C_CBZ;
      ins[31:24] == 8'b10110101:     cls = C_CBNZ;
      ins[31:24] == 8'b01010100:     cls = C_BC;
      ins[31:21] == 11'b11010110000: cls = C_BR;
      default:                       cls = C_ILL;
    endcase
  end

  // Sign-extended word offset for the PC adder.
  always_comb begin
    kval = '0;
    unique case (cls)
      C_B, C_BL:
        kval = {{(DATA_W-28){ins[25]}}, ins[25:0], 2'b00};
      C_BC, C_CBZ, C_CBNZ:
        kval = {{(DATA_W-21){ins[23]}}, ins[23:5], 2'b00};
      default: kval = '0;
    endcase
  end

  // B.cond predicate over latched {V,C,N,Z}.
  always_comb begin
    cond_ok = 1'b0;
    unique case (ins[3:0])
      4'h0: cond_ok = flags_q[0];
      4'h1: cond_ok = !flags_q[0];
      4'h2: cond_ok = flags_q[2];
      4'h3: cond_ok = !flags_q[2];
      4'h4: cond_ok = flags_q[1];
      4'h5: cond_ok = !flags_q[1];
      4'h6: cond_ok = flags_q[3];
      4'h7: cond_ok = !flags_q[3];
      4'h8: cond_ok = flags_q[2] & !flags_q[0];
      4'h9: cond_ok = !(flags_q[2] & !flags_q[0]);
      4'hA: cond_ok = (flags_q[1] == flags_q[3]);
      4'hB: cond_ok = (flags_q[1] != flags_q[3]);
      4'hC: cond_ok = !flags_q[0] & (flags_q[1] == flags_q[3]);
      4'hD: cond_ok = !(!flags_q[0] & (flags_q[1] == flags_q[3]));
      default: cond_ok = 1'b1;
    endcase
  end

  // Branch decision; Zalu is taken live during EVAL.
  always_comb begin
    eval_tk = 1'b0;
    unique case (cls)
      C_B, C_BL, C_BR: eval_tk = 1'b1;
      C_CBZ:           eval_tk = status[4];
      C_CBNZ:          eval_tk = !status[4];
      C_BC:            eval_tk = cond_ok;
      default:         eval_tk = 1'b0;
    endcase
  end

  // Next state and registered outputs for the coming cycle.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    flags_d = flags_q;
    tk_d    = (state_q == S_EVAL) ? eval_tk : tk_q;
    cw_d    = CW_NOP;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_EVAL;
        instr_d = instruction;
        flags_d = status[3:0];
      end
      S_EVAL: state_d = (cls == C_BL && LINK_EN) ? S_LINK : S_JUMP;
      S_LINK: state_d = S_JUMP;
      default: state_d = S_IDLE;
    endcase
    unique case (state_d)
      S_EVAL: if (cls == C_CBZ || cls == C_CBNZ) begin
        cw_d.sb     = ins[4:0];
        cw_d.fsel   = FSEL_PASS_B;
        cw_d.en_alu = 1'b1;
      end
      S_LINK: begin
        cw_d.da    = LINK_REG;
        cw_d.regw  = 1'b1;
        cw_d.en_pc = 1'b1;
      end
      S_JUMP: begin
        cw_d.sl = 1'b1;
        if (!tk_d) begin
          cw_d.psel = 2'b01;
        end else if (cls == C_BR) begin
          cw_d.psel   = 2'b11;
          cw_d.sa     = ins[9:5];
          cw_d.fsel   = FSEL_PASS_A;
          cw_d.en_alu = 1'b1;
          cw_d.pcsel  = 1'b1;
        end else begin
          cw_d.psel  = 2'b10;
          cw_d.pcsel = 1'b1;
        end
      end
      default: cw_d = CW_NOP;
    endcase
    k_d    = (state_d == S_IDLE) ? '0 : kval;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_JUMP);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      flags_q <= '0;
      tk_q    <= 1'b0;
      cw_q    <= CW_NOP;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      flags_q <= flags_d;
      tk_q    <= tk_d;
      cw_q    <= cw_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign controlword = cw_q;
  assign K           = k_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign taken       = done_q & tk_q;
  assign illegal     = done_q & (cls == C_ILL);

endmodule
